// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral slice.
// Contents:
//   OFF_*        byte offsets of each register from BASE_ADDR (address[1:0] ignored)
//   WINDOW_SPAN  size of the decoded window; offsets 0x00..0x1B hit
//   TCON_*       bit positions inside the timer control register
//   timer_wr_t   per-register write strobes from the decoder to the timer
package mmio_pkg;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_SW      = 5'h10;
    localparam logic [4:0] OFF_DIGITS  = 5'h14;
    localparam logic [4:0] OFF_SYSTICK = 5'h18;

    // Last mapped word is at 0x18, so any byte offset below 0x1C is inside.
    localparam logic [31:0] WINDOW_SPAN = 32'h0000_001C;

    localparam int TCON_W     = 3;
    localparam int TCON_EN    = 0;
    localparam int TCON_IRQEN = 1;
    localparam int TCON_IRQST = 2;

    typedef struct packed {
        logic th;
        logic tl;
        logic tcon;
    } timer_wr_t;

endpackage

// File: rtl/mmio_peripheral_if.sv
// MEM-stage bus between the CPU and the peripheral.
// Signals:
//   MemRead, MemWrite  access strobes from the MEM stage
//   address            byte address (ex_mem ALU result)
//   write_data         store data (ex_mem rt)
//   read_data          combinational read data back to the MEM/WB mux
//   hit                address falls inside the peripheral window
interface mmio_peripheral_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;

    modport master (
        output MemRead,
        output MemWrite,
        output address,
        output write_data,
        input  read_data,
        input  hit
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  address,
        input  write_data,
        output read_data,
        output hit
    );

endinterface

// File: rtl/peripheral_timer.sv
// Reloadable up-counting timer with overflow interrupt.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   wr          write strobes for TH / TL / TCON from the address decoder
//   wdata       CPU store data
//   th, tl      reload value and current count
//   tcon        [0] enable, [1] irq enable, [2] irq status
//   irq         irq_en & irq_status
module peripheral_timer
    import mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  timer_wr_t         wr,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic              overflow;
    logic [TCON_W-1:0] tcon_next;

    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    // A CPU write lands first, then an overflow may force the status bit back
    // on, so a clear racing an overflow never loses the interrupt.
    always_comb begin
        tcon_next = tcon;
        if (wr.tcon) begin
            tcon_next = wdata[TCON_W-1:0];
        end
        if (overflow && tcon[TCON_IRQEN]) begin
            tcon_next[TCON_IRQST] = 1'b1;
        end
    end

    // TH written this cycle only matters from the next cycle: the reload
    // reads the registered th, i.e. the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr.th) begin
                th <= wdata;
            end
            if (wr.tl) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= overflow ? th : tl + 32'd1;
            end
            tcon <= tcon_next;
        end
    end

    assign irq = tcon[TCON_IRQEN] & tcon[TCON_IRQST];

endmodule

// File: rtl/mmio_peripheral.sv
// Memory-mapped peripheral slave in parallel with DataMemory on the MEM stage.
// Provides a reloadable timer with interrupt, LED and 7-segment registers,
// a synchronised switch input and a free-running system tick.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   bus         MEM-stage slave port (strobes, address, data, hit)
//   switch      raw asynchronous board switches
//   led         LED register
//   digits      7-segment register, [11:8] anode, [7:0] segment
//   irq         timer interrupt request
module mmio_peripheral
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_WIDTH = 8,
    parameter int          SW_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_peripheral_if.slave     bus,
    input  logic [SW_WIDTH-1:0]  switch,
    output logic [LED_WIDTH-1:0] led,
    output logic [11:0]          digits,
    output logic                 irq
);

    logic [31:0]         offset;
    logic [4:0]          word;
    logic                hit;
    logic                wr_en;
    timer_wr_t           timer_wr;
    logic                wr_led;
    logic                wr_digits;
    logic [31:0]         th;
    logic [31:0]         tl;
    logic [TCON_W-1:0]   tcon;
    logic [31:0]         systick;
    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_sync;
    logic [31:0]         rdata;

    // Subtracting the base makes addresses below BASE_ADDR wrap to huge
    // values, so one unsigned compare covers both window edges.
    assign offset = bus.address - BASE_ADDR;
    assign hit    = offset < WINDOW_SPAN;
    assign word   = {offset[4:2], 2'b00};
    assign wr_en  = bus.MemWrite & hit;

    always_comb begin
        timer_wr  = '0;
        wr_led    = 1'b0;
        wr_digits = 1'b0;
        if (wr_en) begin
            case (word)
                OFF_TH:     timer_wr.th   = 1'b1;
                OFF_TL:     timer_wr.tl   = 1'b1;
                OFF_TCON:   timer_wr.tcon = 1'b1;
                OFF_LED:    wr_led        = 1'b1;
                OFF_DIGITS: wr_digits     = 1'b1;
                default:    ;
            endcase
        end
    end

    peripheral_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .wr    (timer_wr),
        .wdata (bus.write_data),
        .th    (th),
        .tl    (tl),
        .tcon  (tcon),
        .irq   (irq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            digits  <= '0;
            systick <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            if (wr_led) begin
                led <= bus.write_data[LED_WIDTH-1:0];
            end
            if (wr_digits) begin
                digits <= bus.write_data[11:0];
            end
            systick <= systick + 32'd1;
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // Reads see registered state only, so a same-cycle write is not visible.
    always_comb begin
        rdata = '0;
        if (bus.MemRead && hit) begin
            case (word)
                OFF_TH:      rdata = th;
                OFF_TL:      rdata = tl;
                OFF_TCON:    rdata = {{(32-TCON_W){1'b0}}, tcon};
                OFF_LED:     rdata = {{(32-LED_WIDTH){1'b0}}, led};
                OFF_SW:      rdata = {{(32-SW_WIDTH){1'b0}}, sw_sync};
                OFF_DIGITS:  rdata = {20'h0_0000, digits};
                OFF_SYSTICK: rdata = systick;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.read_data = rdata;
    assign bus.hit       = hit;

endmodule

// File: doc/mmio_peripheral.md
Name: mmio_peripheral

Overview:
Memory-mapped peripheral slave on the CPU's MEM stage. It sits in parallel with DataMemory, driven by the same MemRead, MemWrite, address and write_data signals. It provides a reloadable timer with interrupt, LED and 7-segment output registers, a synchronised switch input and a free-running system tick. Its read data is muxed with DataMemory output into MEM/WB, and its irq output feeds the planned exception/interrupt logic.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the peripheral window; word offsets below are added to it
LED_WIDTH, 8, width of LED output register
SW_WIDTH, 8, width of switch input

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
MemRead  input  1  read strobe from the MEM stage
MemWrite  input  1  write strobe from the MEM stage
address  input  32  byte address from ex_mem ALU output
write_data  input  32  store data (ex_mem rt)
read_data  output  32  combinational read data
hit  output  1  address lies in the decoded window (BASE_ADDR .. BASE_ADDR+0x18)
switch  input  SW_WIDTH  raw board switches (asynchronous)
led  output  LED_WIDTH  LED register
digits  output  12  7-segment register: [11:8] anode, [7:0] segment
irq  output  1  timer interrupt request

Behaviour:
- Register map, word offsets; address[1:0] ignored:
  - 0x00 TH: reload value, RW
  - 0x04 TL: counter, RW
  - 0x08 TCON: bits [2:0] RW, upper bits read 0
  - 0x0C LED: RW
  - 0x10 SW: RO, zero-extended
  - 0x14 DIGITS: RW, 12 bits, upper bits read 0
  - 0x18 SYSTICK: RO
- TCON bits: [0] enable, [1] irq_en, [2] irq_status.
- Reset, asynchronous: TH, TL, TCON, LED, DIGITS, SYSTICK, both switch sync stages = 0. Outputs led=0, digits=0, irq=0.
- Read path: read_data = register value when MemRead & hit, else 0. Zero latency, same cycle.
- Write path: on rising clk when MemWrite & hit.
  - Writes to SW and SYSTICK are ignored.
  - Unmapped offsets inside the window: hit=1, reads return 0, writes ignored.
- Timer, each clk with TCON[0]=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and if TCON[1]=1 set TCON[2].
  - Otherwise TL<=TL+1.
  - With TCON[0]=0, TL holds.
- Priority, same cycle:
  - CPU write to TL beats the timer update.
  - CPU write to TH takes effect from the next cycle; a reload in the same cycle uses the old TH.
  - Overflow setting TCON[2] beats a CPU write clearing it, so no interrupt is lost. The bits [1:0] of that write still apply.
- irq = TCON[1] & TCON[2], registered-state combinational. It stays asserted until software clears TCON[2].
- SYSTICK increments every cycle and wraps 0xFFFF_FFFF -> 0.
- Switch input: 2-flop synchroniser; SW reads the second stage, giving 2-cycle latency.
- Read and write to the same register in one cycle: read returns the pre-write value.
- Reset asserted mid-count clears everything immediately, with no clock needed.

Decomposition:
- Shared package mmio_pkg:
  - offset constants OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGITS, OFF_SYSTICK
  - TCON bit indices TCON_EN, TCON_IRQEN, TCON_IRQST
- One sub-module, peripheral_timer: holds TH/TL/TCON, the reload/overflow logic and the irq output. Register write strobes and write_data come in from the decoder in mmio_peripheral.

Test Plan:
- Reset then read every offset with MemRead=1 -> all read 0; irq=0, led=0, digits=0; SYSTICK read one cycle after reset release = 1.
- Write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3 -> TL sequence FFFF_FFFF, FFFF_FFFD, FFFF_FFFE, FFFF_FFFF, FFFF_FFFD. TCON[2] and irq rise on the first reload cycle and stay high.
- With the timer overflowing every 3 cycles, write TCON=3 (clear status) in the exact overflow cycle -> TCON reads 7 next cycle and irq stays 1. Writing TCON=3 one cycle later -> irq drops to 0.
- Write LED=0xA5 and DIGITS=0xE3F at BASE_ADDR+0x0C/+0x14 -> led=8'hA5 and digits=12'hE3F after the clk edge. Write 0x1234 to SYSTICK -> no change to its count.
- Drive switch=0x5A -> SW read still returns the old value after 1 edge, returns 0x0000_005A after 2 edges. Access to BASE_ADDR+0x1C -> hit=0, read_data=0. Access to 0x0000_0010 -> hit=0.
- Assert reset asynchronously mid-count with TCON=7 -> irq, TL, TCON go to 0 before the next clk edge.
